sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Command arbiter between the 16-bit SDRAM controller (SDRAM_16bit) and its two clients: the cache controller (256-byte line fill/flush) and the video refill path (32-byte bursts into vqueue).
- Lives in the SDRAM clock domain.
- Picks one command per cycle and tracks the video scan address with wrap.
- Routes returned data: halfwords pack into 32-bit vqueue writes, or become cache strobes.

Parameters:
- VID_WORDS, 19200, 32-byte video bursts per frame (640*480*2/32); vid_adr wraps to 0 after VID_WORDS-1.
- VADR_W, 19, width of vid_adr.
- CADR_W, 17, width of cache line address (256-byte granularity).

Ports:
- clk  in  1  SDRAM clock (clk_sdr domain).
- rst  in  1  asynchronous active-low reset.
- vid_en  in  1  video refill enabled (system out of reset).
- vid_low  in  1  vqueue almost-empty (synchronous to clk).
- cache_wr_req  in  1  cache requests 256-byte write-back.
- cache_rd_req  in  1  cache requests 256-byte line fill.
- cache_waddr  in  CADR_W  write-back line address.
- cache_raddr  in  CADR_W  line-fill address.
- sys_cmd  out  2  00 nop, 01 write 256B, 10 read 32B, 11 read 256B.
- sys_addr  out  23  word address to controller.
- sys_cmd_ack  in  2  controller command acknowledge.
- sys_rd_data_valid  in  1  read halfword valid.
- sys_wr_data_valid  in  1  controller consuming write halfword.
- sys_dout  in  16  read halfword.
- vq_data  out  32  packed video word {second halfword, first halfword}.
- vq_we  out  1  vqueue write strobe.
- cache_wdata_stb  out  1  write returned halfword into cache.
- cache_rdata_stb  out  1  cache supplies next halfword.
- vid_adr  out  VADR_W  current video burst index.

Behaviour:
- Reset (rst=0, async): sys_cmd=00, vid_adr=0, crw=0, phase=0, vq_we=0, vq_data=0, prev_nop=1.
- sys_cmd is registered and re-evaluated every cycle. Fixed priority:
  - (vid_en & vid_low) -> 10
  - else cache_wr_req -> 01
  - else cache_rd_req -> 11
  - else 00
- sys_addr is combinational from the registered sys_cmd:
  - 01 -> {cache_waddr,6'b0}
  - 10 -> {1'b1,vid_adr,3'b0}
  - 11 -> {cache_raddr,6'b0}
  - 00 -> 0
- prev_nop <= (sys_cmd_ack==00). An ack is accepted only when prev_nop=1, i.e. on a 00->non-00 transition, so a multi-cycle ack counts once.
- Accepted ack 10:
  - crw<=0.
  - vid_adr <= (vid_adr==VID_WORDS-1) ? 0 : vid_adr+1.
- Accepted ack 01 or 11: crw<=1. The crw value holds until the next accepted ack.
- Video data path (crw=0 & sys_rd_data_valid):
  - phase=0: latch sys_dout into low, phase<=1.
  - phase=1: vq_data<={sys_dout,low}, vq_we<=1 for exactly one cycle, phase<=0.
  - Latency: second halfword to vq_we is 1 cycle. A 32B burst gives 8 vq_we pulses.
- Cache strobes are combinational, zero latency:
  - cache_wdata_stb = crw & sys_rd_data_valid
  - cache_rdata_stb = crw & sys_wr_data_valid
- vid_en=0: no video commands issue. A burst already in flight still completes and packs.
- Simultaneous video and cache requests: video wins every cycle, so cache requests starve while vid_low stays high. This is intended; the FIFO threshold bounds it.
- Reset mid-burst: all state clears immediately; the partially packed word is discarded.

Optional Feature:
- Macro: VID_VSYNC_RESYNC_EN.
- With the macro:
  - Extra input vsync (1 bit, already synchronised to clk).
  - On a rising edge of vsync, vid_adr<=0 and phase<=0.
  - An edge coinciding with an accepted 10 ack forces vid_adr to 0; the ack's increment is dropped.
- Without the macro: no vsync port; vid_adr advances only by ack and wrap.

Decomposition:
- Shared package sdram_pkg holds:
  - Command codes CMD_NOP=2'b00, CMD_WR256=2'b01, CMD_RD32=2'b10, CMD_RD256=2'b11.
  - Video region bit VID_REGION=1'b1.
  - Default VID_WORDS.
- One natural sub-module, vid_pack16to32: phase flip-flop, low-half latch and vq_we generation.
- Arbitration, ack tracking and address muxing stay in sdram_arbiter.

Test Plan:
- Reset release, vid_en=1, vid_low=1, cache idle -> sys_cmd=10 next cycle, sys_addr={1,19'd0,3'd0}. After ack 10 (held 3 cycles), vid_adr=1, incremented once only.
- vid_adr preset to 19199 via acks, one more ack 10 -> vid_adr=0, sys_addr=23'h400000.
- crw=0, rd_data_valid halfwords 0x1111,0x2222 -> one vq_we, vq_data=0x22221111 one cycle after 0x2222. 16 halfwords -> 8 pulses.
- cache_wr_req=1, cache_waddr=17'h00A5, vid_low=0 -> sys_cmd=01, sys_addr=23'h002940. Ack 01, then 128 wr_data_valid -> 128 cache_rdata_stb, no vq_we.
- vid_low=1 and cache_rd_req=1 together -> sys_cmd=10. Drop vid_low -> sys_cmd=11 next cycle.
- VID_VSYNC_RESYNC_EN: vid_adr=500, vsync rising -> vid_adr=0, phase=0. Pulse rst low mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter: command codes, the
// video region bit and default geometry of the video frame.
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WR256 = 2'b01,
    CMD_RD32  = 2'b10,
    CMD_RD256 = 2'b11
  } cmd_e;

  localparam logic VID_REGION        = 1'b1;
  localparam int   VID_WORDS_DEFAULT = 19200;  // 640*480*2/32 bursts per frame
  localparam int   VADR_W_DEFAULT    = 19;
  localparam int   CADR_W_DEFAULT    = 17;
  localparam int   SYS_ADDR_W        = 23;

endpackage : sdram_pkg

// File: rtl/sdram_arbiter_if.sv
// Command/data bus between the arbiter and the 16-bit SDRAM controller.
// The arbiter drives commands through the master modport; the controller
// side uses the slave modport.
interface sdram_arbiter_if;

  logic [1:0]  sys_cmd;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid;
  logic        sys_wr_data_valid;
  logic [15:0] sys_dout;

  modport master (
    output sys_cmd, sys_addr,
    input  sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
  );

  modport slave (
    input  sys_cmd, sys_addr,
    output sys_cmd_ack, sys_rd_data_valid, sys_wr_data_valid, sys_dout
  );

endinterface : sdram_arbiter_if

// File: rtl/vid_pack16to32.sv
// Packs pairs of returned SDRAM halfwords into 32-bit vqueue words.
// The first halfword of a pair is held in a latch; the second completes
// the word and raises vq_we for a single cycle. clr drops a half-packed
// word (used for frame resynchronisation).
module vid_pack16to32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        hw_valid,
  input  logic [15:0] hw_data,
  output logic [31:0] vq_data,
  output logic        vq_we
);

  logic        phase_r;
  logic [15:0] low_r;

  // Phase toggle, low-half latch and one-cycle write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_r <= 1'b0;
      low_r   <= 16'h0000;
      vq_data <= 32'h0000_0000;
      vq_we   <= 1'b0;
    end else if (clr) begin
      phase_r <= 1'b0;
      vq_we   <= 1'b0;
    end else if (hw_valid) begin
      if (!phase_r) begin
        low_r   <= hw_data;
        phase_r <= 1'b1;
        vq_we   <= 1'b0;
      end else begin
        vq_data <= {hw_data, low_r};
        vq_we   <= 1'b1;
        phase_r <= 1'b0;
      end
    end else begin
      vq_we <= 1'b0;
    end
  end

endmodule : vid_pack16to32

// File: rtl/sdram_arbiter.sv
// Command arbiter between the SDRAM controller and its two clients
// (cache line fill/flush and video refill). Picks one command per cycle
// with video first, tracks the video burst address with frame wrap, and
// routes returned data either to the vqueue packer or to cache strobes.
// Optional build macro VID_VSYNC_RESYNC_EN adds a vsync input that
// restarts the video scan address on its rising edge.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int VID_WORDS = VID_WORDS_DEFAULT,
  parameter int VADR_W    = VADR_W_DEFAULT,
  parameter int CADR_W    = CADR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_en,
  input  logic              vid_low,
  input  logic              cache_wr_req,
  input  logic              cache_rd_req,
  input  logic [CADR_W-1:0] cache_waddr,
  input  logic [CADR_W-1:0] cache_raddr,
`ifdef VID_VSYNC_RESYNC_EN
  input  logic              vsync,
`endif
  sdram_arbiter_if.master   sys,
  output logic [31:0]       vq_data,
  output logic              vq_we,
  output logic              cache_wdata_stb,
  output logic              cache_rdata_stb,
  output logic [VADR_W-1:0] vid_adr
);

  cmd_e              cmd_r;
  cmd_e              cmd_nxt_s;
  logic              prev_nop_r;
  logic              crw_r;
  logic              ack_acc_s;
  logic              resync_s;
  logic [VADR_W-1:0] vid_adr_r;
  logic [VADR_W-1:0] vid_adr_nxt_s;
  logic [SYS_ADDR_W-1:0] addr_s;

`ifdef VID_VSYNC_RESYNC_EN
  logic vsync_q_r;

  // Remember last vsync level to detect its rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q_r <= 1'b0;
    end else begin
      vsync_q_r <= vsync;
    end
  end

  assign resync_s = vsync & ~vsync_q_r;
`else
  assign resync_s = 1'b0;
`endif

  // Fixed-priority command selection: video refill, write-back, line fill.
  always_comb begin
    cmd_nxt_s = CMD_NOP;
    if (vid_en && vid_low) begin
      cmd_nxt_s = CMD_RD32;
    end else if (cache_wr_req) begin
      cmd_nxt_s = CMD_WR256;
    end else if (cache_rd_req) begin
      cmd_nxt_s = CMD_RD256;
    end else begin
      cmd_nxt_s = CMD_NOP;
    end
  end

  // Registered command, re-evaluated every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_r <= CMD_NOP;
    end else begin
      cmd_r <= cmd_nxt_s;
    end
  end

  // Word address for the command currently presented to the controller.
  always_comb begin
    addr_s = {SYS_ADDR_W{1'b0}};
    case (cmd_r)
      CMD_WR256: addr_s = {cache_waddr, 6'b00_0000};
      CMD_RD32:  addr_s = {VID_REGION, vid_adr_r, 3'b000};
      CMD_RD256: addr_s = {cache_raddr, 6'b00_0000};
      CMD_NOP:   addr_s = {SYS_ADDR_W{1'b0}};
      default:   addr_s = {SYS_ADDR_W{1'b0}};
    endcase
  end

  assign sys.sys_cmd  = cmd_r;
  assign sys.sys_addr = addr_s;

  // An ack counts only on the cycle it rises out of nop, so a held ack
  // is taken once.
  assign ack_acc_s = prev_nop_r && (sys.sys_cmd_ack != 2'b00);

  // Next video burst index: wrap at end of frame, vsync edge overrides.
  always_comb begin
    vid_adr_nxt_s = vid_adr_r;
    if (resync_s) begin
      vid_adr_nxt_s = {VADR_W{1'b0}};
    end else if (ack_acc_s && (sys.sys_cmd_ack == CMD_RD32)) begin
      if (vid_adr_r == VADR_W'(VID_WORDS - 1)) begin
        vid_adr_nxt_s = {VADR_W{1'b0}};
      end else begin
        vid_adr_nxt_s = vid_adr_r + VADR_W'(1);
      end
    end else begin
      vid_adr_nxt_s = vid_adr_r;
    end
  end

  // Ack history, data routing owner (crw) and video address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_nop_r <= 1'b1;
      crw_r      <= 1'b0;
      vid_adr_r  <= {VADR_W{1'b0}};
    end else begin
      prev_nop_r <= (sys.sys_cmd_ack == 2'b00);
      vid_adr_r  <= vid_adr_nxt_s;
      if (ack_acc_s) begin
        crw_r <= (sys.sys_cmd_ack != CMD_RD32);
      end else begin
        crw_r <= crw_r;
      end
    end
  end

  assign vid_adr         = vid_adr_r;
  assign cache_wdata_stb = crw_r & sys.sys_rd_data_valid;
  assign cache_rdata_stb = crw_r & sys.sys_wr_data_valid;

  vid_pack16to32 u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (resync_s),
    .hw_valid (~crw_r & sys.sys_rd_data_valid),
    .hw_data  (sys.sys_dout),
    .vq_data  (vq_data),
    .vq_we    (vq_we)
  );

endmodule : sdram_arbiter
